// File: rtl/onfi_bus_arbiter_if.sv
// Bundle of the handshake and pin signals shared between the ONFI command
// sub-blocks (master side) and onfi_bus_arbiter (slave side).
interface onfi_bus_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ-1:0]    done;
    logic [NUM_REQ-1:0]    gnt;
    logic                  busy;
    logic [ID_W-1:0]       owner_id;
    logic                  timeout_err;

    logic [NUM_REQ-1:0]    req_cen;
    logic [NUM_REQ-1:0]    req_cle;
    logic [NUM_REQ-1:0]    req_ale;
    logic [NUM_REQ-1:0]    req_wen;
    logic [NUM_REQ-1:0]    req_dq_en;
    logic [32*NUM_REQ-1:0] req_dq_o;

    logic                  onfi_cen;
    logic                  onfi_cle;
    logic                  onfi_ale;
    logic                  onfi_wen;
    logic                  onfi_dq_en;
    logic [31:0]           onfi_dq_o;

    // Requesters and the pad ring.
    modport master (
        output req, done, req_cen, req_cle, req_ale, req_wen, req_dq_en, req_dq_o,
        input  gnt, busy, owner_id, timeout_err,
               onfi_cen, onfi_cle, onfi_ale, onfi_wen, onfi_dq_en, onfi_dq_o
    );

    // The arbiter.
    modport slave (
        input  req, done, req_cen, req_cle, req_ale, req_wen, req_dq_en, req_dq_o,
        output gnt, busy, owner_id, timeout_err,
               onfi_cen, onfi_cle, onfi_ale, onfi_wen, onfi_dq_en, onfi_dq_o
    );
endinterface

// File: rtl/onfi_bus_arbiter.sv
// Round-robin owner of the shared ONFI pin set with an idle gap between owners.
// Optional forced release of a stuck owner when ONFI_ARB_TIMEOUT_EN is defined.
module onfi_bus_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int GAP_CYC     = 2,
    parameter int TIMEOUT_CYC = 1024,
    parameter int ID_W        = 2
) (
    input  logic              onfi_clk,
    input  logic              rst,
    onfi_bus_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    generate
        if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
            $error("onfi_bus_arbiter: NUM_REQ must be 2..8");
        end
        if (ID_W != $clog2(NUM_REQ)) begin : g_bad_id_w
            $error("onfi_bus_arbiter: ID_W must equal clog2(NUM_REQ)");
        end
        if (GAP_CYC < 0 || GAP_CYC > 15) begin : g_bad_gap
            $error("onfi_bus_arbiter: GAP_CYC must be 0..15");
        end
        if (TIMEOUT_CYC < 2) begin : g_bad_timeout
            $error("onfi_bus_arbiter: TIMEOUT_CYC must be at least 2");
        end
    endgenerate

    state_t             state_reg;
    logic [NUM_REQ-1:0] gnt_reg;
    logic [ID_W-1:0]    owner_reg;
    logic [ID_W-1:0]    rr_reg;
    logic [3:0]         gap_cnt_reg;

    logic [ID_W:0]      cand_sum  [NUM_REQ];
    logic [ID_W:0]      cand_wrap [NUM_REQ];
    logic [ID_W-1:0]    cand_idx  [NUM_REQ];
    logic [31:0]        dq_arr    [NUM_REQ];

    logic [ID_W-1:0]    sel_idx;
    logic [ID_W-1:0]    rr_next;
    logic               sel_found;
    logic               owner_release;
    logic               tmo_hit;
    logic               own_active;

    // Candidate gi is the requester gi places after the rr pointer, modulo NUM_REQ.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            assign cand_sum[gi]  = {1'b0, rr_reg} + (ID_W+1)'(gi);
            assign cand_wrap[gi] = cand_sum[gi] - (ID_W+1)'(NUM_REQ);
            assign cand_idx[gi]  = (cand_sum[gi] >= (ID_W+1)'(NUM_REQ)) ?
                                   cand_wrap[gi][ID_W-1:0] : cand_sum[gi][ID_W-1:0];
            assign dq_arr[gi]    = bus.req_dq_o[32*gi +: 32];
        end
    endgenerate

    // Walk from the farthest candidate back to the nearest so the nearest set one wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req[cand_idx[k]]) begin
                sel_found = 1'b1;
                sel_idx   = cand_idx[k];
            end
        end
    end

    assign rr_next       = (sel_idx == ID_W'(NUM_REQ - 1)) ? '0 : sel_idx + ID_W'(1);
    assign owner_release = bus.done[owner_reg] | ~bus.req[owner_reg];

    always_ff @(posedge onfi_clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            gnt_reg     <= '0;
            owner_reg   <= '0;
            rr_reg      <= '0;
            gap_cnt_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (sel_found) begin
                        gnt_reg   <= NUM_REQ'(1) << sel_idx;
                        owner_reg <= sel_idx;
                        rr_reg    <= rr_next;
                        state_reg <= ST_OWN;
                    end
                end
                ST_OWN: begin
                    if (owner_release || tmo_hit) begin
                        gnt_reg     <= '0;
                        gap_cnt_reg <= '0;
                        state_reg   <= (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_reg == 4'(GAP_CYC - 1)) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + 4'd1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    gnt_reg   <= '0;
                end
            endcase
        end
    end

`ifdef ONFI_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC);

    logic [TMO_W-1:0] tmo_cnt_reg;
    logic             timeout_err_reg;

    // Counter reads 0 in the first OWN cycle, so a hit lands on OWN cycle TIMEOUT_CYC.
    assign tmo_hit = (state_reg == ST_OWN) && (tmo_cnt_reg == TMO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge onfi_clk) begin
        if (rst) begin
            tmo_cnt_reg     <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            timeout_err_reg <= tmo_hit && !owner_release;
            if (state_reg == ST_OWN && !owner_release && !tmo_hit) begin
                tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
            end else begin
                tmo_cnt_reg <= '0;
            end
        end
    end

    assign bus.timeout_err = timeout_err_reg;
`else
    assign tmo_hit         = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    // Pins come straight from the owner's bundle so its own edge timing is preserved.
    assign own_active     = (state_reg == ST_OWN);
    assign bus.onfi_cen   = own_active ? bus.req_cen[owner_reg]   : 1'b1;
    assign bus.onfi_cle   = own_active ? bus.req_cle[owner_reg]   : 1'b0;
    assign bus.onfi_ale   = own_active ? bus.req_ale[owner_reg]   : 1'b0;
    assign bus.onfi_wen   = own_active ? bus.req_wen[owner_reg]   : 1'b1;
    assign bus.onfi_dq_en = own_active ? bus.req_dq_en[owner_reg] : 1'b0;
    assign bus.onfi_dq_o  = own_active ? dq_arr[owner_reg]        : 32'h0;

    assign bus.gnt      = gnt_reg;
    assign bus.busy     = (state_reg != ST_IDLE);
    assign bus.owner_id = owner_reg;

endmodule

// File: tb/tb_onfi_bus_arbiter.sv
// Directed bench for onfi_bus_arbiter: instance a uses GAP_CYC=2/TIMEOUT_CYC=16,
// instance b uses GAP_CYC=0. Honours ONFI_ARB_TIMEOUT_EN for the timeout case.
module tb_onfi_bus_arbiter;

    logic onfi_clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   n;
    int   gap_seen;
    int   idle_seen;
    int   bad;
    logic [1:0] exp_own;

    onfi_bus_arbiter_if #(.NUM_REQ(4), .ID_W(2)) bus_a ();
    onfi_bus_arbiter_if #(.NUM_REQ(4), .ID_W(2)) bus_b ();

    onfi_bus_arbiter #(.NUM_REQ(4), .GAP_CYC(2), .TIMEOUT_CYC(16), .ID_W(2)) dut_a (
        .onfi_clk (onfi_clk),
        .rst      (rst),
        .bus      (bus_a)
    );

    onfi_bus_arbiter #(.NUM_REQ(4), .GAP_CYC(0), .TIMEOUT_CYC(16), .ID_W(2)) dut_b (
        .onfi_clk (onfi_clk),
        .rst      (rst),
        .bus      (bus_b)
    );

    always #5 onfi_clk = ~onfi_clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end else begin
            $display("ok   %s: got %0h", tag, act);
        end
    endtask

    task automatic tick();
        @(posedge onfi_clk);
        #1;
    endtask

    task automatic tick_n(input int cnt);
        repeat (cnt) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus_a.req       = '0;  bus_b.req       = '0;
        bus_a.done      = '0;  bus_b.done      = '0;
        bus_a.req_cen   = '0;  bus_b.req_cen   = '0;
        bus_a.req_cle   = '0;  bus_b.req_cle   = '0;
        bus_a.req_ale   = '0;  bus_b.req_ale   = '0;
        bus_a.req_wen   = '0;  bus_b.req_wen   = '0;
        bus_a.req_dq_en = '1;  bus_b.req_dq_en = '1;
        bus_a.req_dq_o  = {32'hFF, 32'hEE, 32'hDD, 32'hCC};
        bus_b.req_dq_o  = {32'hFF, 32'hEE, 32'hDD, 32'hCC};
        tick_n(2);

        // Reset state
        check_val("rst_gnt",   32'(bus_a.gnt), 32'h0);
        check_val("rst_busy",  32'(bus_a.busy), 32'h0);
        check_val("rst_owner", 32'(bus_a.owner_id), 32'h0);
        check_val("rst_cen",   32'(bus_a.onfi_cen), 32'h1);
        check_val("rst_wen",   32'(bus_a.onfi_wen), 32'h1);
        check_val("rst_dq_en", 32'(bus_a.onfi_dq_en), 32'h0);
        check_val("rst_dq",    bus_a.onfi_dq_o, 32'h0);
        check_val("rst_terr",  32'(bus_a.timeout_err), 32'h0);
        rst = 1'b0;

        // Single requester 2, pin pass-through
        bus_a.req = 4'b0100;
        tick();
        check_val("t1_gnt",   32'(bus_a.gnt), 32'h4);
        check_val("t1_owner", 32'(bus_a.owner_id), 32'h2);
        check_val("t1_busy",  32'(bus_a.busy), 32'h1);
        check_val("t1_dq",    bus_a.onfi_dq_o, 32'hEE);
        check_val("t1_cen",   32'(bus_a.onfi_cen), 32'h0);
        bus_a.req_cle[2] = 1'b1;
        #1;
        check_val("t1_cle_hi", 32'(bus_a.onfi_cle), 32'h1);
        bus_a.req_cle[2] = 1'b0;
        #1;
        check_val("t1_cle_lo", 32'(bus_a.onfi_cle), 32'h0);
        bus_a.req = 4'b0000;
        tick();
        check_val("t1_rel_gnt",  32'(bus_a.gnt), 32'h0);
        check_val("t1_rel_busy", 32'(bus_a.busy), 32'h1);
        check_val("t1_rel_cen",  32'(bus_a.onfi_cen), 32'h1);
        tick_n(2);
        check_val("t1_idle_busy",  32'(bus_a.busy), 32'h0);
        check_val("t1_idle_owner", 32'(bus_a.owner_id), 32'h2);

        // Round robin 0,1,2,3,0 with GAP_CYC=2 spacing
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus_a.req = 4'b1111;
        tick();
        for (int k = 0; k < 4; k++) begin
            exp_own = 2'(k);
            check_val("t2_owner", 32'(bus_a.owner_id), 32'(exp_own));
            check_val("t2_gnt",   32'(bus_a.gnt), 32'h1 << exp_own);
            tick();
            check_val("t2_cen_own", 32'(bus_a.onfi_cen), 32'h0);
            tick();
            bus_a.done[exp_own] = 1'b1;
            tick();
            bus_a.done = '0;
            n = 0;
            gap_seen = 0;
            idle_seen = 0;
            while (bus_a.gnt == 4'b0000 && n < 20) begin
                if (bus_a.busy) gap_seen++;
                if (bus_a.onfi_cen) idle_seen++;
                tick();
                n++;
            end
            check_val("t2_edges_to_next", 32'(n), 32'd3);
            check_val("t2_gap_cycles",    32'(gap_seen), 32'd2);
            check_val("t2_idle_pins",     32'(idle_seen), 32'd3);
        end
        check_val("t2_wrap_owner", 32'(bus_a.owner_id), 32'h0);

        // Non-owner done ignored, owner done releases
        check_val("t3_gnt", 32'(bus_a.gnt), 32'h1);
        bus_a.done[1] = 1'b1;
        tick();
        bus_a.done = '0;
        check_val("t3_ignore_gnt", 32'(bus_a.gnt), 32'h1);
        bus_a.done[0] = 1'b1;
        tick();
        bus_a.done = '0;
        bus_a.req = 4'b0000;
        check_val("t3_rel_gnt", 32'(bus_a.gnt), 32'h0);
        tick_n(3);
        check_val("t3_idle_busy", 32'(bus_a.busy), 32'h0);

        // Reset during the 3rd OWN cycle of owner 3
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus_a.req = 4'b1000;
        tick();
        check_val("t4_gnt",   32'(bus_a.gnt), 32'h8);
        check_val("t4_owner", 32'(bus_a.owner_id), 32'h3);
        tick_n(2);
        check_val("t4_wen_own", 32'(bus_a.onfi_wen), 32'h0);
        rst = 1'b1;
        tick();
        check_val("t4_rst_gnt",   32'(bus_a.gnt), 32'h0);
        check_val("t4_rst_busy",  32'(bus_a.busy), 32'h0);
        check_val("t4_rst_cen",   32'(bus_a.onfi_cen), 32'h1);
        check_val("t4_rst_wen",   32'(bus_a.onfi_wen), 32'h1);
        check_val("t4_rst_owner", 32'(bus_a.owner_id), 32'h0);
        rst = 1'b0;
        tick();
        check_val("t4_regnt", 32'(bus_a.gnt), 32'h8);
        bus_a.req = 4'b0000;
        tick_n(4);

        // GAP_CYC=0: back-to-back handover
        bus_b.req = 4'b0011;
        tick();
        check_val("t5_first_gnt", 32'(bus_b.gnt), 32'h1);
        tick();
        bus_b.done[0] = 1'b1;
        tick();
        bus_b.done = '0;
        check_val("t5_rel_gnt",  32'(bus_b.gnt), 32'h0);
        check_val("t5_rel_busy", 32'(bus_b.busy), 32'h0);
        tick();
        check_val("t5_next_gnt",   32'(bus_b.gnt), 32'h2);
        check_val("t5_next_owner", 32'(bus_b.owner_id), 32'h1);
        bus_b.req = 4'b0000;
        tick();
        check_val("t5_end_gnt", 32'(bus_b.gnt), 32'h0);

        // Owner 1 never releases
        bus_a.req = 4'b0010;
        tick();
        check_val("t6_gnt", 32'(bus_a.gnt), 32'h2);
`ifdef ONFI_ARB_TIMEOUT_EN
        n = 0;
        while (bus_a.gnt != 4'b0000 && n < 40) begin
            tick();
            n++;
        end
        check_val("t6_own_cycles", 32'(n), 32'd16);
        check_val("t6_terr_hi",    32'(bus_a.timeout_err), 32'h1);
        check_val("t6_terr_owner", 32'(bus_a.owner_id), 32'h1);
        tick();
        check_val("t6_terr_lo", 32'(bus_a.timeout_err), 32'h0);
`else
        bad = 0;
        for (int i = 0; i < 110; i++) begin
            tick();
            if (bus_a.gnt !== 4'b0010 || bus_a.timeout_err !== 1'b0) bad++;
        end
        check_val("t6_hold_bad_cycles", 32'(bad), 32'd0);
        check_val("t6_hold_gnt",  32'(bus_a.gnt), 32'h2);
        check_val("t6_hold_terr", 32'(bus_a.timeout_err), 32'h0);
`endif
        bus_a.req = 4'b0000;
        tick_n(4);
        check_val("t6_end_busy", 32'(bus_a.busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
